// File: rtl/lin_to_log_pipe_pkg.sv
// Shared constants and field types for the linear-to-log converter.
// The pipeline's log_val_t depends on EXP_W, so it is declared in the top module from these types.
package lin_to_log_pipe_pkg;

    localparam int unsigned LOG_FRAC_W = 5;
    localparam int unsigned LIN_FRAC_W = 9;
    localparam int unsigned LUT_W      = LOG_FRAC_W + 1;

    typedef logic [LIN_FRAC_W-1:0] lin_frac_t;
    typedef logic [LOG_FRAC_W-1:0] log_frac_t;
    typedef logic [LUT_W-1:0]      lut_out_t;

endpackage

// File: rtl/lin_to_log_pipe_if.sv
// Valid/ready bus for lin_to_log_pipe: linear words in, log-domain results out.
// The master modport is the surrounding datapath; the slave modport is the converter.
interface lin_to_log_pipe_if
    import lin_to_log_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned EXP_W = $clog2(WIDTH) + 1
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] out_int;
    log_frac_t        out_frac;
    logic             out_zero;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_int, out_frac, out_zero
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_int, out_frac, out_zero
    );

endinterface

// File: rtl/log2_lut_9x5.sv
// L(f) = round-half-up(32*log2(1 + f/512)) for a 9-bit mantissa fraction f, result 0..32.
// Ranges are the breakpoints of the 512-entry table, computed offline from that formula.
module log2_lut_9x5
    import lin_to_log_pipe_pkg::*;
(
    input  lin_frac_t i_f,
    output lut_out_t  o_l
);

    always_comb begin
        o_l = '0;
        case (i_f) inside
            [9'd0   : 9'd5  ]: o_l = 6'd0;
            [9'd6   : 9'd16 ]: o_l = 6'd1;
            [9'd17  : 9'd28 ]: o_l = 6'd2;
            [9'd29  : 9'd40 ]: o_l = 6'd3;
            [9'd41  : 9'd52 ]: o_l = 6'd4;
            [9'd53  : 9'd64 ]: o_l = 6'd5;
            [9'd65  : 9'd77 ]: o_l = 6'd6;
            [9'd78  : 9'd90 ]: o_l = 6'd7;
            [9'd91  : 9'd103]: o_l = 6'd8;
            [9'd104 : 9'd116]: o_l = 6'd9;
            [9'd117 : 9'd130]: o_l = 6'd10;
            [9'd131 : 9'd144]: o_l = 6'd11;
            [9'd145 : 9'd159]: o_l = 6'd12;
            [9'd160 : 9'd173]: o_l = 6'd13;
            [9'd174 : 9'd188]: o_l = 6'd14;
            [9'd189 : 9'd204]: o_l = 6'd15;
            [9'd205 : 9'd219]: o_l = 6'd16;
            [9'd220 : 9'd235]: o_l = 6'd17;
            [9'd236 : 9'd252]: o_l = 6'd18;
            [9'd253 : 9'd269]: o_l = 6'd19;
            [9'd270 : 9'd286]: o_l = 6'd20;
            [9'd287 : 9'd303]: o_l = 6'd21;
            [9'd304 : 9'd321]: o_l = 6'd22;
            [9'd322 : 9'd339]: o_l = 6'd23;
            [9'd340 : 9'd358]: o_l = 6'd24;
            [9'd359 : 9'd377]: o_l = 6'd25;
            [9'd378 : 9'd396]: o_l = 6'd26;
            [9'd397 : 9'd416]: o_l = 6'd27;
            [9'd417 : 9'd437]: o_l = 6'd28;
            [9'd438 : 9'd458]: o_l = 6'd29;
            [9'd459 : 9'd479]: o_l = 6'd30;
            [9'd480 : 9'd500]: o_l = 6'd31;
            default:           o_l = 6'd32;
        endcase
    end

endmodule

// File: rtl/lin_to_log_pipe.sv
// Two-stage linear-to-log converter: leading-one normalize, then log-fraction lookup with carry.
// Build option LIN_TO_LOG_ROUND_EN: round the 9-bit mantissa half-up instead of truncating it.
module lin_to_log_pipe
    import lin_to_log_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned EXP_W = $clog2(WIDTH) + 1
)
(
    input  logic              clock,
    input  logic              resetn,
    lin_to_log_pipe_if.slave  bus
);

    typedef struct packed {
        logic             zero;
        logic [EXP_W-1:0] ipart;
        log_frac_t        frac;
    } log_val_t;

`ifdef LIN_TO_LOG_ROUND_EN
    localparam int unsigned GW = LIN_FRAC_W + 1;
`else
    localparam int unsigned GW = LIN_FRAC_W;
`endif

    logic             w_s1_load;
    logic             w_s2_load;
    logic [EXP_W-1:0] w_lead;
    logic             w_zero;
    logic [GW-1:0]    w_g;
    lin_frac_t        w_f;
    logic [EXP_W-1:0] w_e;
    lut_out_t         w_l;
    log_val_t         w_s2_next;

    logic             r_s1_valid;
    logic             r_s1_zero;
    logic [EXP_W-1:0] r_s1_e;
    lin_frac_t        r_s1_f;
    logic             r_s2_valid;
    log_val_t         r_s2;

    assign w_s2_load    = !r_s2_valid || bus.out_ready;
    assign w_s1_load    = !r_s1_valid || w_s2_load;
    assign bus.in_ready = w_s1_load;

    always_comb begin
        w_lead = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.in_data[i]) w_lead = EXP_W'(i);
        end
    end

    assign w_zero = ~|bus.in_data;

    // After appending GW zeros and shifting right by e, the leading one sits just above
    // the kept bits, so the truncation leaves the left-aligned mantissa (plus round bit).
    assign w_g = GW'({bus.in_data, {GW{1'b0}}} >> w_lead);

`ifdef LIN_TO_LOG_ROUND_EN
    logic [LIN_FRAC_W:0] w_fsum;

    assign w_fsum = {1'b0, w_g[GW-1:1]} + {{LIN_FRAC_W{1'b0}}, w_g[0]};
    assign w_f    = w_fsum[LIN_FRAC_W-1:0];
    assign w_e    = w_lead + EXP_W'(w_fsum[LIN_FRAC_W]);
`else
    assign w_f = w_g;
    assign w_e = w_lead;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_e     <= '0;
            r_s1_f     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_zero <= w_zero;
                r_s1_e    <= w_e;
                r_s1_f    <= w_f;
            end
        end
    end

    log2_lut_9x5 u_lut (
        .i_f (r_s1_f),
        .o_l (w_l)
    );

    always_comb begin
        w_s2_next.zero  = r_s1_zero;
        w_s2_next.ipart = r_s1_e;
        w_s2_next.frac  = w_l[LOG_FRAC_W-1:0];
        if (w_l[LOG_FRAC_W]) begin
            w_s2_next.ipart = r_s1_e + EXP_W'(1);
            w_s2_next.frac  = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2 <= w_s2_next;
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_int   = r_s2.ipart;
    assign bus.out_frac  = r_s2.frac;
    assign bus.out_zero  = r_s2.zero;

endmodule

// File: tb/tb_lin_to_log_pipe.sv
// Directed and streaming checks for lin_to_log_pipe at WIDTH = 16.
module tb_lin_to_log_pipe;

    logic clk;
    logic rst_n;

    lin_to_log_pipe_if #(.WIDTH(16)) bus ();

    lin_to_log_pipe #(.WIDTH(16)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       z;
        logic [4:0] i;
        logic [4:0] f;
    } res_t;

    typedef struct {
        logic [15:0] din;
        logic [4:0]  ei;
        logic [4:0]  ef;
        logic        ez;
    } vec_t;

    res_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_emit = 0;
    logic        last_acc;
    logic        last_rdy;

    function automatic res_t model(input logic [15:0] x);
        int          e;
        int unsigned m;
        int unsigned f;
        real         l;
        int          li;
        res_t        r;
        r = '0;
        if (x == 16'd0) begin
            r.z = 1'b1;
            return r;
        end
        e = 0;
        for (int k = 0; k < 16; k++) if (x[k]) e = k;
        m = 32'(x) - (32'd1 << e);
        if (e >= 9) f = m >> (e - 9);
        else        f = m << (9 - e);
`ifdef LIN_TO_LOG_ROUND_EN
        if (e >= 10) f = f + ((m >> (e - 10)) & 32'd1);
        if (f == 512) begin
            f = 0;
            e = e + 1;
        end
`endif
        l  = 32.0 * $ln(1.0 + real'(f) / 512.0) / $ln(2.0);
        li = int'($floor(l + 0.5));
        if (li == 32) begin
            r.i = 5'(e + 1);
            r.f = '0;
        end else begin
            r.i = 5'(e);
            r.f = 5'(li);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample mid-cycle, let the edge happen, score transfers, settle 1 time unit.
    task automatic tick();
        logic        acc;
        logic        emit;
        logic [15:0] din;
        res_t        got;
        res_t        want;
        #3;
        acc      = bus.in_valid && bus.in_ready;
        emit     = bus.out_valid && bus.out_ready;
        last_acc = acc;
        last_rdy = bus.in_ready;
        din      = bus.in_data;
        got      = {bus.out_zero, bus.out_int, bus.out_frac};
        @(posedge clk);
        if (acc) exp_q.push_back(model(din));
        if (emit) begin
            n_emit++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got zero %0d int %0d frac %0d, expected none",
                         got.z, got.i, got.f);
            end else begin
                want = exp_q.pop_front();
                chk("stream_result", 32'(got), 32'(want));
            end
        end
        #1;
    endtask

    // Single word through an idle pipe: absent after the accepting edge, present after the next.
    task automatic one_shot(input string tag, input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_data  = v.din;
        tick();
        chk({tag, "_accept"}, 32'(last_acc), 32'd1);
        bus.in_valid = 1'b0;
        chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_int"},   32'(bus.out_int),   32'(v.ei));
        chk({tag, "_frac"},  32'(bus.out_frac),  32'(v.ef));
        chk({tag, "_zero"},  32'(bus.out_zero),  32'(v.ez));
        tick();
    endtask

    vec_t        vt[12];
    logic [15:0] words[100];
    int          n0;
    int          stalls;
    logic [10:0] held;

    initial begin
        vt[0]  = '{16'h0001, 5'd0,  5'd0,  1'b0};
        vt[1]  = '{16'h0002, 5'd1,  5'd0,  1'b0};
        vt[2]  = '{16'h0003, 5'd1,  5'd19, 1'b0};
        vt[3]  = '{16'h0005, 5'd2,  5'd10, 1'b0};
        vt[4]  = '{16'h0006, 5'd2,  5'd19, 1'b0};
        vt[5]  = '{16'h0007, 5'd2,  5'd26, 1'b0};
        vt[6]  = '{16'h0000, 5'd0,  5'd0,  1'b1};
        vt[7]  = '{16'hFFFF, 5'd16, 5'd0,  1'b0};
        vt[8]  = '{16'h8000, 5'd15, 5'd0,  1'b0};
        vt[9]  = '{16'h01FF, 5'd9,  5'd0,  1'b0};
        vt[10] = '{16'h0C00, 5'd11, 5'd19, 1'b0};
`ifdef LIN_TO_LOG_ROUND_EN
        vt[11] = '{16'h040B, 5'd10, 5'd1,  1'b0};
`else
        vt[11] = '{16'h040B, 5'd10, 5'd0,  1'b0};
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_int",   32'(bus.out_int),   32'd0);
        chk("rst_out_frac",  32'(bus.out_frac),  32'd0);
        chk("rst_out_zero",  32'(bus.out_zero),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) one_shot($sformatf("vec%0d", i), vt[i]);

        for (int i = 0; i < 100; i++)
            words[i] = (i % 23 == 0) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
        n0     = n_emit;
        stalls = 0;
        for (int i = 0; i < 102; i++) begin
            bus.in_valid = (i < 100);
            bus.in_data  = (i < 100) ? words[i] : 16'd0;
            tick();
            if (i < 100 && !last_acc) stalls++;
        end
        bus.in_valid = 1'b0;
        chk("stream_no_stall", 32'(stalls), 32'd0);
        chk("stream_count",    32'(n_emit - n0), 32'd100);
        chk("stream_drained",  32'(exp_q.size()), 32'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        tick();
        chk("bp_acc0", 32'(last_acc), 32'd1);
        bus.in_data = 16'h0ABC;
        tick();
        chk("bp_acc1", 32'(last_acc), 32'd1);
        bus.in_data = 16'h7001;
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        held = {bus.out_zero, bus.out_int, bus.out_frac};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_in_ready_low", 32'(last_rdy), 32'd0);
            chk("bp_hold_valid",   32'(bus.out_valid), 32'd1);
            chk("bp_hold_data",    32'({bus.out_zero, bus.out_int, bus.out_frac}), 32'(held));
        end
        n0            = n_emit;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", 32'(last_rdy), 32'd1);
        chk("bp_release_accept",   32'(last_acc), 32'd1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2; k++) tick();
        chk("bp_emitted", 32'(n_emit - n0), 32'd3);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0321;
        tick();
        bus.in_data = 16'h4444;
        tick();
        bus.in_valid = 1'b0;
        chk("rst_mid_full", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        n0    = n_emit;
        for (int k = 0; k < 3; k++) tick();
        chk("rst_no_stale", 32'(n_emit - n0), 32'd0);
        one_shot("after_rst", vt[10]);

        chk("final_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
